// File: rtl/dot_product_8_8x8_sequencer.sv
// ---------------------------------------------------------------------------
// dot_product_8_8x8_sequencer
//
// Feeds the input side of the dot_product_8_8x8 engine from two ready/valid
// streams:
//   * B stream: vectors are written into the engine BRAM via o_b/o_b_addr/
//     o_wren. A load runs until a word carrying i_b_last is accepted.
//   * A stream: items are grouped into dot-product jobs of i_len_m1+1 items.
//     Each item is forwarded with its BRAM read index and o_first/o_last
//     framing.
//   * o_pending counts jobs whose result has not yet come back on
//     i_sum_valid (the engine's o_valid). A new load is held off until every
//     issued job has completed, so B contents never change under a job.
//
// Handshake: a word moves on a rising i_clk edge when valid and ready are both
// high in that cycle. Ready is combinational from the state, o_pending and
// i_b_valid; it never depends on the matching valid. Both readies are held
// low while i_reset_n is low.
//
// Ports:
//   i_clk, i_reset_n          clock, asynchronous active-low reset
//   i_len_m1                  job length minus one, sampled on job start
//   i_b_data/i_b_valid/i_b_last/o_b_ready   B load stream
//   i_a_data/i_a_valid/o_a_ready            A item stream
//   o_b/o_b_addr/o_wren       engine BRAM write port / read index
//   o_a/o_first/o_last        engine item input and job framing
//   i_sum_valid               engine result strobe
//   o_pending                 jobs issued, result not yet returned
//   o_busy                    high while loading or running a job
//   o_err                     sticky: result strobe with nothing pending
//   o_state                   debug view of the sequencer state
// ---------------------------------------------------------------------------
module dot_product_8_8x8_sequencer #(
    parameter int N = 8,
    parameter int M = 8,
    parameter int A = 10,
    parameter int P = 4
) (
    input  logic           i_clk,
    input  logic           i_reset_n,
    input  logic [A-1:0]   i_len_m1,
    input  logic [M*N-1:0] i_b_data,
    input  logic           i_b_valid,
    input  logic           i_b_last,
    output logic           o_b_ready,
    input  logic [M*N-1:0] i_a_data,
    input  logic           i_a_valid,
    output logic           o_a_ready,
    output logic [M*N-1:0] o_b,
    output logic [A-1:0]   o_b_addr,
    output logic           o_wren,
    output logic [M*N-1:0] o_a,
    output logic           o_first,
    output logic           o_last,
    input  logic           i_sum_valid,
    output logic [P-1:0]   o_pending,
    output logic           o_busy,
    output logic           o_err,
    output logic [1:0]     o_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [A-1:0] wr_ptr;     // next BRAM write address during LOAD
    logic [A-1:0] item_idx;   // index of the next item during RUN
    logic [A-1:0] len_q;      // latched job length minus one

    logic pend_zero, pend_full;
    logic b_ready_raw, a_ready_raw;
    logic b_acc, a_acc;
    logic [A-1:0] cur_waddr, cur_idx, cur_len;
    logic item_last;
    logic pend_inc, pend_dec;

    assign pend_zero = (o_pending == '0);
    assign pend_full = (o_pending == '1);

    // -----------------------------------------------------------------------
    // Ready generation. In IDLE a waiting B word wins over A, and a new job
    // cannot start once the pending counter is at its maximum.
    // -----------------------------------------------------------------------
    always_comb begin
        b_ready_raw = 1'b0;
        a_ready_raw = 1'b0;
        unique case (state)
            IDLE: begin
                b_ready_raw = pend_zero;
                a_ready_raw = !(i_b_valid && pend_zero) && !pend_full;
            end
            LOAD: b_ready_raw = 1'b1;
            RUN:  a_ready_raw = 1'b1;
            default: begin
                b_ready_raw = 1'b0;
                a_ready_raw = 1'b0;
            end
        endcase
    end

    assign o_b_ready = b_ready_raw & i_reset_n;
    assign o_a_ready = a_ready_raw & i_reset_n;

    assign b_acc = i_b_valid & o_b_ready;
    assign a_acc = i_a_valid & o_a_ready;

    // A word or item accepted in IDLE is word/item 0 of a new operation, so
    // the counters are read as zero there and the live i_len_m1 is used.
    assign cur_waddr = (state == IDLE) ? '0 : wr_ptr;
    assign cur_idx   = (state == IDLE) ? '0 : item_idx;
    assign cur_len   = (state == IDLE) ? i_len_m1 : len_q;
    assign item_last = (cur_idx == cur_len);

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (b_acc) begin
                    state_nxt = i_b_last ? IDLE : LOAD;
                end else if (a_acc) begin
                    state_nxt = item_last ? IDLE : RUN;
                end
            end
            LOAD: begin
                if (b_acc && i_b_last) begin
                    state_nxt = IDLE;
                end
            end
            RUN: begin
                if (a_acc && item_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign o_busy  = (state != IDLE);
    assign o_state = state;

    // -----------------------------------------------------------------------
    // Registered engine drive. Idle cycles present a zero item with no
    // framing, which leaves the engine's running sum unchanged; o_b_addr and
    // o_b keep their last values.
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_b      <= '0;
            o_b_addr <= '0;
            o_wren   <= 1'b0;
            o_a      <= '0;
            o_first  <= 1'b0;
            o_last   <= 1'b0;
            wr_ptr   <= '0;
            item_idx <= '0;
            len_q    <= '0;
        end else begin
            o_wren  <= 1'b0;
            o_a     <= '0;
            o_first <= 1'b0;
            o_last  <= 1'b0;
            if (b_acc) begin
                o_b      <= i_b_data;
                o_b_addr <= cur_waddr;
                o_wren   <= 1'b1;
                wr_ptr   <= cur_waddr + 1'b1;   // wraps naturally at 2^A
            end else if (a_acc) begin
                o_a      <= i_a_data;
                o_b_addr <= cur_idx;
                o_first  <= (cur_idx == '0);
                o_last   <= item_last;
                item_idx <= cur_idx + 1'b1;
                if (state == IDLE) begin
                    len_q <= i_len_m1;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Pending-result counter. The increment lines up with o_last going high.
    // A result strobe with nothing pending is dropped and flagged.
    // -----------------------------------------------------------------------
    assign pend_inc = a_acc & item_last;
    assign pend_dec = i_sum_valid & !pend_zero;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_pending <= '0;
            o_err     <= 1'b0;
        end else begin
            if (pend_inc && !pend_dec) begin
                o_pending <= o_pending + 1'b1;
            end else if (pend_dec && !pend_inc) begin
                o_pending <= o_pending - 1'b1;
            end
            if (i_sum_valid && pend_zero) begin
                o_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dot_product_8_8x8_sequencer.sv
module tb_dot_product_8_8x8_sequencer;

  localparam int N = 8;
  localparam int M = 8;
  localparam int A = 10;
  localparam int P = 4;
  localparam int W = M * N;
  localparam int DEPTH = 1 << A;
  localparam int PMAX = (1 << P) - 1;

  // ---------------- clock / reset ----------------
  logic i_clk = 1'b0;
  logic i_reset_n = 1'b0;
  always #5 i_clk = ~i_clk;

  logic [A-1:0] i_len_m1 = '0;
  logic [W-1:0] i_b_data = '0;
  logic         i_b_valid = 1'b0;
  logic         i_b_last = 1'b0;
  logic         o_b_ready;
  logic [W-1:0] i_a_data = '0;
  logic         i_a_valid = 1'b0;
  logic         o_a_ready;
  logic [W-1:0] o_b;
  logic [A-1:0] o_b_addr;
  logic         o_wren;
  logic [W-1:0] o_a;
  logic         o_first;
  logic         o_last;
  logic         i_sum_valid = 1'b0;
  logic [P-1:0] o_pending;
  logic         o_busy;
  logic         o_err;
  logic [1:0]   o_state;

  dot_product_8_8x8_sequencer #(.N(N), .M(M), .A(A), .P(P)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_len_m1(i_len_m1),
    .i_b_data(i_b_data), .i_b_valid(i_b_valid), .i_b_last(i_b_last),
    .o_b_ready(o_b_ready), .i_a_data(i_a_data), .i_a_valid(i_a_valid),
    .o_a_ready(o_a_ready), .o_b(o_b), .o_b_addr(o_b_addr), .o_wren(o_wren),
    .o_a(o_a), .o_first(o_first), .o_last(o_last), .i_sum_valid(i_sum_valid),
    .o_pending(o_pending), .o_busy(o_busy), .o_err(o_err), .o_state(o_state)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_tests = 0;
  int n_fail = 0;

  function automatic void chk(input string name, input logic [W-1:0] act,
                              input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  // Transaction view: mode (0 idle, 1 loading, 2 inside a job), next load
  // address, job length and items still to come in the job, result count.
  int           m_mode;
  int           m_wptr;
  int           m_jlen;
  int           m_left;
  int           m_pend;
  bit           m_err;
  logic [W-1:0] e_b, e_a;
  int           e_addr;
  bit           e_wren, e_first, e_last;

  function automatic void model_reset();
    m_mode = 0; m_wptr = 0; m_jlen = 1; m_left = 0; m_pend = 0; m_err = 0;
    e_b = '0; e_a = '0; e_addr = 0; e_wren = 0; e_first = 0; e_last = 0;
  endfunction

  function automatic void model_ready(output bit brdy, output bit ardy);
    case (m_mode)
      0: begin
        brdy = (m_pend == 0);
        ardy = !(i_b_valid && m_pend == 0) && (m_pend != PMAX);
      end
      1: begin brdy = 1; ardy = 0; end
      default: begin brdy = 0; ardy = 1; end
    endcase
  endfunction

  function automatic void model_step(input bit acc_b, input bit acc_a);
    bit dec;
    e_wren = 0; e_a = '0; e_first = 0; e_last = 0;
    if (acc_b) begin
      e_addr = (m_mode == 0) ? 0 : m_wptr;
      e_b = i_b_data;
      e_wren = 1;
      m_wptr = (e_addr + 1) % DEPTH;
      m_mode = i_b_last ? 0 : 1;
    end else if (acc_a) begin
      if (m_mode == 0) begin
        m_jlen = int'(i_len_m1) + 1;
        m_left = m_jlen;
      end
      e_a = i_a_data;
      e_addr = m_jlen - m_left;
      e_first = (m_left == m_jlen);
      e_last = (m_left == 1);
      m_left--;
      m_mode = (m_left == 0) ? 0 : 2;
    end
    dec = i_sum_valid && (m_pend > 0);
    if (i_sum_valid && m_pend == 0) m_err = 1;
    m_pend = m_pend + (e_last ? 1 : 0) - (dec ? 1 : 0);
  endfunction

  function automatic void check_outputs();
    chk("o_wren", o_wren, e_wren);
    chk("o_b", o_b, e_b);
    chk("o_b_addr", o_b_addr, e_addr);
    chk("o_a", o_a, e_a);
    chk("o_first", o_first, e_first);
    chk("o_last", o_last, e_last);
    chk("o_pending", o_pending, m_pend);
    chk("o_busy", o_busy, m_mode != 0);
    chk("o_err", o_err, m_err);
  endfunction

  // ---------------- driver tasks ----------------
  // Inputs are already applied (just after the previous rising edge).
  // Readies are sampled on the falling edge, outputs 1 ns after the rise.
  task automatic step(output bit got_brdy, output bit got_ardy);
    bit brdy, ardy;
    @(negedge i_clk);
    got_brdy = o_b_ready;
    got_ardy = o_a_ready;
    model_ready(brdy, ardy);
    chk("b_ready", o_b_ready, brdy);
    chk("a_ready", o_a_ready, ardy);
    model_step(i_b_valid && brdy, i_a_valid && ardy);
    @(posedge i_clk);
    #1;
    check_outputs();
  endtask

  task automatic clear_in();
    i_b_valid = 0; i_b_last = 0; i_a_valid = 0; i_sum_valid = 0;
  endtask

  task automatic push_a(input int len_m1);
    bit br, ar;
    clear_in();
    i_a_valid = 1;
    i_len_m1 = A'(len_m1);
    i_a_data = {$urandom, $urandom};
    step(br, ar);
  endtask

  task automatic idle_step(input bit sum);
    bit br, ar;
    clear_in();
    i_sum_valid = sum;
    step(br, ar);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit bv, bl, av, sv;
    int len;
    bit brdy, ardy, wren, first, last;
    int addr, pend;
    bit busy;
  } vec_t;

  vec_t tab[16];

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    bit br, ar;
    logic [W-1:0] pat;

    //                bv bl av sv len brdy ardy wren first last addr pend busy
    tab[0]  = '{1, 0, 0, 0, 0,  1, 0, 1, 0, 0,  0, 0, 1};
    tab[1]  = '{1, 0, 0, 0, 0,  1, 0, 1, 0, 0,  1, 0, 1};
    tab[2]  = '{1, 0, 0, 0, 0,  1, 0, 1, 0, 0,  2, 0, 1};
    tab[3]  = '{1, 1, 0, 0, 0,  1, 0, 1, 0, 0,  3, 0, 0};
    tab[4]  = '{0, 0, 0, 0, 0,  1, 1, 0, 0, 0,  3, 0, 0};
    tab[5]  = '{0, 0, 1, 0, 0,  1, 1, 0, 1, 1,  0, 1, 0};
    tab[6]  = '{0, 0, 1, 0, 0,  0, 1, 0, 1, 1,  0, 2, 0};
    tab[7]  = '{0, 0, 1, 0, 0,  0, 1, 0, 1, 1,  0, 3, 0};
    tab[8]  = '{0, 0, 0, 1, 0,  0, 1, 0, 0, 0,  0, 2, 0};
    tab[9]  = '{0, 0, 0, 1, 0,  0, 1, 0, 0, 0,  0, 1, 0};
    tab[10] = '{0, 0, 0, 1, 0,  0, 1, 0, 0, 0,  0, 0, 0};
    tab[11] = '{1, 1, 1, 0, 0,  1, 0, 1, 0, 0,  0, 0, 0};
    tab[12] = '{0, 0, 1, 0, 0,  1, 1, 0, 1, 1,  0, 1, 0};
    tab[13] = '{1, 1, 0, 0, 0,  0, 1, 0, 0, 0,  0, 1, 0};
    tab[14] = '{1, 1, 0, 1, 0,  0, 1, 0, 0, 0,  0, 0, 0};
    tab[15] = '{1, 1, 0, 0, 0,  1, 0, 1, 0, 0,  0, 0, 0};

    // ---- reset ----
    model_reset();
    i_reset_n = 0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_b_ready", o_b_ready, 0);
    chk("rst_a_ready", o_a_ready, 0);
    check_outputs();
    @(negedge i_clk);
    i_reset_n = 1;
    @(posedge i_clk);
    #1;

    // ---- table: 4-word load, single-item jobs, B priority, B blocked ----
    for (int i = 0; i < 16; i++) begin
      pat = {8{8'(i + 1)}};
      i_b_valid = tab[i].bv; i_b_last = tab[i].bl;
      i_a_valid = tab[i].av; i_sum_valid = tab[i].sv;
      i_len_m1 = A'(tab[i].len);
      i_b_data = pat; i_a_data = pat;
      step(br, ar);
      chk($sformatf("tab%0d_b_ready", i), br, tab[i].brdy);
      chk($sformatf("tab%0d_a_ready", i), ar, tab[i].ardy);
      chk($sformatf("tab%0d_wren", i), o_wren, tab[i].wren);
      chk($sformatf("tab%0d_first", i), o_first, tab[i].first);
      chk($sformatf("tab%0d_last", i), o_last, tab[i].last);
      chk($sformatf("tab%0d_addr", i), o_b_addr, tab[i].addr);
      chk($sformatf("tab%0d_pend", i), o_pending, tab[i].pend);
      chk($sformatf("tab%0d_busy", i), o_busy, tab[i].busy);
      if (tab[i].wren) chk($sformatf("tab%0d_b", i), o_b, pat);
      // every A acceptance in this table is a single-item job
      chk($sformatf("tab%0d_a", i), o_a, tab[i].first ? pat : '0);
    end
    clear_in();

    // ---- 8-item job, continuous ----
    for (int k = 0; k < 8; k++) begin
      push_a(7);
      chk("job8_first", o_first, k == 0);
      chk("job8_last", o_last, k == 7);
      chk("job8_addr", o_b_addr, k);
    end
    idle_step(0);
    chk("job8_pend", o_pending, 1);
    idle_step(1);
    chk("job8_pend_ret", o_pending, 0);

    // ---- 8-item job with a 2-cycle gap after item 3 ----
    for (int k = 0; k < 4; k++) push_a(7);
    for (int g = 0; g < 2; g++) begin
      idle_step(0);
      chk("gap_a", o_a, '0);
      chk("gap_addr", o_b_addr, 3);
      chk("gap_first", o_first, 0);
      chk("gap_last", o_last, 0);
      chk("gap_busy", o_busy, 1);
    end
    for (int k = 4; k < 8; k++) begin
      push_a(7);
      chk("gap_job_last", o_last, k == 7);
    end
    idle_step(1);

    // ---- saturate pending at 15 ----
    for (int k = 0; k < PMAX; k++) push_a(0);
    chk("sat_pend", o_pending, PMAX);
    clear_in();
    i_a_valid = 1; i_b_valid = 1; i_len_m1 = '0;
    step(br, ar);
    chk("sat_a_ready", ar, 0);
    chk("sat_b_ready", br, 0);
    for (int k = 0; k < PMAX; k++) idle_step(1);
    chk("sat_drained", o_pending, 0);

    // ---- long load wrapping the write pointer ----
    for (int k = 0; k < DEPTH + 2; k++) begin
      clear_in();
      i_b_valid = 1;
      i_b_last = (k == DEPTH + 1);
      i_b_data = {$urandom, $urandom};
      step(br, ar);
      if (k == DEPTH - 1) chk("wrap_top", o_b_addr, DEPTH - 1);
      if (k == DEPTH) chk("wrap_zero", o_b_addr, 0);
    end
    clear_in();

    // ---- randomized traffic ----
    for (int c = 0; c < 800; c++) begin
      i_b_valid = ($urandom_range(0, 3) == 0);
      i_b_last = ($urandom_range(0, 3) == 0);
      i_b_data = {$urandom, $urandom};
      i_a_valid = $urandom_range(0, 1);
      i_a_data = {$urandom, $urandom};
      i_len_m1 = A'($urandom_range(0, 6));
      i_sum_valid = (m_pend > 0) && ($urandom_range(0, 4) == 0);
      step(br, ar);
    end

    // ---- bring to a clean idle, then reset mid-job ----
    for (int k = 0; k < 20 && m_mode != 0; k++) begin
      clear_in();
      if (m_mode == 1) begin i_b_valid = 1; i_b_last = 1; end
      else i_a_valid = 1;
      step(br, ar);
    end
    for (int k = 0; k < 20 && m_pend != 0; k++) idle_step(1);
    chk("pre_rst_idle", o_busy, 0);
    push_a(0);
    for (int k = 0; k < 5; k++) push_a(7);
    chk("pre_rst_pend", o_pending, 1);
    i_a_valid = 1;
    i_a_data = {$urandom, $urandom};
    #2;
    i_reset_n = 0;
    #1;
    model_reset();
    chk("arst_b_ready", o_b_ready, 0);
    chk("arst_a_ready", o_a_ready, 0);
    check_outputs();
    @(posedge i_clk);
    #1;
    chk("arst_no_last", o_last, 0);
    chk("arst_pend", o_pending, 0);
    @(negedge i_clk);
    i_reset_n = 1;
    clear_in();
    @(posedge i_clk);
    #1;
    idle_step(1);
    chk("err_set", o_err, 1);
    idle_step(0);
    chk("err_sticky", o_err, 1);
    chk("err_pend", o_pending, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
